// File: rtl/vslide_pkg.sv
// Shared types and constants for the vector slide sequencer.
package vslide_pkg;

  localparam int REQ_DATA_WIDTH    = 64;
  localparam int REQ_ADDR_WIDTH    = 32;
  localparam int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8;
  localparam int SHIFT_WIDTH       = $clog2(REQ_BYTE_EN_WIDTH);
  localparam int OFF_WIDTH         = 12;
  localparam int CNT_WIDTH         = OFF_WIDTH - SHIFT_WIDTH + 1;

  localparam int BYTES_PER_WORD = 8;
  localparam int DRAIN_CYCLES   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Per-beat metadata travelling alongside the VRF read
  typedef struct packed {
    logic [REQ_DATA_WIDTH-1:0]    vec1;
    logic [SHIFT_WIDTH-1:0]       shift;
    logic                         start;
    logic                         last;
    logic                         opsel;
    logic                         insert;
    logic [REQ_ADDR_WIDTH-1:0]    addr;
    logic [REQ_BYTE_EN_WIDTH-1:0] be;
    logic [OFF_WIDTH-1:0]         off;
  } beat_t;

  // Number of 64-bit words covering nbytes (rounded up)
  function automatic logic [CNT_WIDTH-1:0] words_of(input logic [OFF_WIDTH-1:0] nbytes);
    logic [OFF_WIDTH:0] s;
    s = {1'b0, nbytes} + (OFF_WIDTH+1)'(BYTES_PER_WORD - 1);
    return CNT_WIDTH'(s >> SHIFT_WIDTH);
  endfunction

endpackage

// File: rtl/vslide_beat_gen.sv
// Computes per-beat metadata from the word index and latched command,
// registered alongside the VRF read strobe.
module vslide_beat_gen
  import vslide_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [CNT_WIDTH-1:0]      idx,
  input  logic [CNT_WIDTH-1:0]      nwords,
  input  logic                      opsel,
  input  logic                      insert,
  input  logic [REQ_DATA_WIDTH-1:0] scalar,
  input  logic [OFF_WIDTH-1:0]      offset,
  input  logic [OFF_WIDTH-1:0]      nbytes,
  input  logic [REQ_ADDR_WIDTH-1:0] dst_base,
  output beat_t                     beat
);

  beat_t                     b;
  logic [REQ_ADDR_WIDTH-1:0] woff;
  logic [SHIFT_WIDTH-1:0]    tail;

  assign woff = REQ_ADDR_WIDTH'(offset[OFF_WIDTH-1:SHIFT_WIDTH]);
  assign tail = nbytes[SHIFT_WIDTH-1:0];

  // Beat fields; slide-up skews the destination by the word offset,
  // slide-down skews the source instead.
  always_comb begin
    b        = '0;
    b.start  = (idx == '0);
    b.last   = (idx == nwords - CNT_WIDTH'(1));
    b.shift  = offset[SHIFT_WIDTH-1:0];
    b.opsel  = opsel;
    b.insert = insert;
    b.off    = offset;
    b.addr   = dst_base + REQ_ADDR_WIDTH'(idx) + (opsel ? '0 : woff);
    b.be     = (b.last && tail != '0) ? ~({REQ_BYTE_EN_WIDTH{1'b1}} << tail)
                                      : {REQ_BYTE_EN_WIDTH{1'b1}};
    b.vec1   = (insert && ((!opsel && b.start) || (opsel && b.last))) ? scalar : '0;
  end

  // Stage p1: capture metadata in step with the read strobe, zero when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) beat <= '0;
    else      beat <= req ? b : '0;
  end

endmodule

// File: rtl/vslide_seq.sv
// Slide command sequencer: walks the source group through the VRF read
// port and emits one registered beat per word for the slide datapath.
module vslide_seq
  import vslide_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_opsel,
  input  logic                         cmd_insert,
  input  logic [REQ_DATA_WIDTH-1:0]    cmd_scalar,
  input  logic [OFF_WIDTH-1:0]         cmd_offset,
  input  logic [OFF_WIDTH-1:0]         cmd_nbytes,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_src_base,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_dst_base,
  output logic                         rd_req,
  output logic [REQ_ADDR_WIDTH-1:0]    rd_addr,
  input  logic [REQ_DATA_WIDTH-1:0]    rd_data,
  output logic                         out_valid,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec0,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec1,
  output logic [SHIFT_WIDTH-1:0]       out_shift,
  output logic                         out_start,
  output logic                         out_end,
  output logic                         out_opsel,
  output logic                         out_insert,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
  output logic [OFF_WIDTH-1:0]         out_off,
  output logic                         busy
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                    state, state_nxt;
  logic                      hs, hs_q, last_rd;
  logic [CNT_WIDTH-1:0]      idx, nwords;
  logic [DW-1:0]             drain_cnt;
  logic                      c_opsel, c_insert;
  logic [REQ_DATA_WIDTH-1:0] c_scalar;
  logic [OFF_WIDTH-1:0]      c_offset, c_nbytes;
  logic [REQ_ADDR_WIDTH-1:0] c_src, c_dst;
  logic [2:1]                vld_pipe;
  beat_t                     beat_p1, beat_p2;

  assign hs      = cmd_valid & cmd_ready;
  assign last_rd = (idx == nwords - CNT_WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state; zero-length commands never leave IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs && words_of(cmd_nbytes) != '0) state_nxt = ISSUE;
      ISSUE:   if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; ready drops for the cycle after any accept so that a
  // zero-length command is still visibly consumed.
  always_comb begin
    cmd_ready = (state == IDLE) && !hs_q;
    rd_req    = (state == ISSUE);
    busy      = (state != IDLE);
    rd_addr   = '0;
    if (state == ISSUE)
      rd_addr = c_src + REQ_ADDR_WIDTH'(idx)
              + (c_opsel ? REQ_ADDR_WIDTH'(c_offset[OFF_WIDTH-1:SHIFT_WIDTH]) : '0);
  end

  // Command latch, word index and drain counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q      <= 1'b0;
      idx       <= '0;
      nwords    <= '0;
      drain_cnt <= '0;
      c_opsel   <= 1'b0;
      c_insert  <= 1'b0;
      c_scalar  <= '0;
      c_offset  <= '0;
      c_nbytes  <= '0;
      c_src     <= '0;
      c_dst     <= '0;
    end else begin
      hs_q <= hs;
      if (hs) begin
        idx      <= '0;
        nwords   <= words_of(cmd_nbytes);
        c_opsel  <= cmd_opsel;
        c_insert <= cmd_insert;
        c_scalar <= cmd_scalar;
        c_offset <= cmd_offset;
        c_nbytes <= cmd_nbytes;
        c_src    <= cmd_src_base;
        c_dst    <= cmd_dst_base;
      end else if (rd_req) begin
        idx <= idx + CNT_WIDTH'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  vslide_beat_gen u_beat (
    .clk      (clk),
    .rst      (rst),
    .req      (rd_req),
    .idx      (idx),
    .nwords   (nwords),
    .opsel    (c_opsel),
    .insert   (c_insert),
    .scalar   (c_scalar),
    .offset   (c_offset),
    .nbytes   (c_nbytes),
    .dst_base (c_dst),
    .beat     (beat_p1)
  );

  // Stage p2: join read data with its metadata; valid follows read by 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      beat_p2  <= '0;
      out_vec0 <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_req};
      beat_p2  <= beat_p1;
      out_vec0 <= vld_pipe[1] ? rd_data : '0;
    end
  end

  assign out_valid  = vld_pipe[2];
  assign out_vec1   = beat_p2.vec1;
  assign out_shift  = beat_p2.shift;
  assign out_start  = beat_p2.start;
  assign out_end    = beat_p2.last;
  assign out_opsel  = beat_p2.opsel;
  assign out_insert = beat_p2.insert;
  assign out_addr   = beat_p2.addr;
  assign out_be     = beat_p2.be;
  assign out_off    = beat_p2.off;

endmodule

// File: tb/tb_vslide_seq.sv
// Directed bench for vslide_seq: records reads and beats, then compares
// them against hand-computed values.
module tb_vslide_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_opsel = 1'b0, cmd_insert = 1'b0;
  logic [63:0] cmd_scalar = '0;
  logic [11:0] cmd_offset = '0, cmd_nbytes = '0;
  logic [31:0] cmd_src_base = '0, cmd_dst_base = '0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [63:0] rd_data = '0;
  logic        out_valid, out_start, out_end, out_opsel, out_insert, busy;
  logic [63:0] out_vec0, out_vec1;
  logic [2:0]  out_shift;
  logic [31:0] out_addr;
  logic [7:0]  out_be;
  logic [11:0] out_off;

  vslide_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opsel(cmd_opsel), .cmd_insert(cmd_insert), .cmd_scalar(cmd_scalar),
    .cmd_offset(cmd_offset), .cmd_nbytes(cmd_nbytes),
    .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_vec0(out_vec0), .out_vec1(out_vec1),
    .out_shift(out_shift), .out_start(out_start), .out_end(out_end),
    .out_opsel(out_opsel), .out_insert(out_insert), .out_addr(out_addr),
    .out_be(out_be), .out_off(out_off), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] v0, v1;
    logic [2:0]  sh;
    logic        st, en, op, ins;
    logic [31:0] a;
    logic [7:0]  be;
    logic [11:0] off;
  } bt_t;

  int          ncmp = 0, nerr = 0, cyc = 0, rdy_cyc = 0;
  logic        rdy_prev = 1'b0;
  int          rd_cyc[$];
  logic [31:0] rd_adr[$];
  bt_t         bq[$];
  bt_t         mb;

  always @(posedge clk) cyc <= cyc + 1;

  // VRF model: one-cycle read latency, data tagged with the word address
  always @(posedge clk) rd_data <= rd_req ? {32'hDA7A_0000, rd_addr} : 64'h0;

  // Record every read strobe, beat and rising edge of cmd_ready
  always @(negedge clk) if (rst) begin
    if (rd_req) begin rd_cyc.push_back(cyc); rd_adr.push_back(rd_addr); end
    if (out_valid) begin
      mb.cyc = cyc; mb.v0 = out_vec0; mb.v1 = out_vec1; mb.sh = out_shift;
      mb.st = out_start; mb.en = out_end; mb.op = out_opsel; mb.ins = out_insert;
      mb.a = out_addr; mb.be = out_be; mb.off = out_off;
      bq.push_back(mb);
    end
    if (cmd_ready && !rdy_prev) rdy_cyc = cyc;
    rdy_prev = cmd_ready;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    rd_cyc.delete(); rd_adr.delete(); bq.delete();
  endtask

  task automatic issue(input logic op, input logic ins, input logic [63:0] sc,
                       input logic [11:0] off, input logic [11:0] nb,
                       input logic [31:0] src, input logic [31:0] dst, input logic keep);
    int n = 0;
    cmd_opsel = op; cmd_insert = ins; cmd_scalar = sc; cmd_offset = off;
    cmd_nbytes = nb; cmd_src_base = src; cmd_dst_base = dst; cmd_valid = 1'b1;
    while (!cmd_ready && n < 40) begin tick(); n++; end
    check("issue ready", 64'(n < 40), 64'd1);
    tick();
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !cmd_ready) && n < 40) begin tick(); n++; end
    check({tag, " idle"}, 64'(n < 40), 64'd1);
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst out_valid", 64'(out_valid), 0);
    check("rst rd_req", 64'(rd_req), 0);
    check("rst busy", 64'(busy), 0);
    check("rst out_addr", 64'(out_addr), 0);
    rst = 1'b1;
    tick();
    check("post-rst ready", 64'(cmd_ready), 1);

    // T1: slide-up, no insert, 3 words
    clear_q();
    issue(1'b0, 1'b0, 64'h0, 12'd3, 12'd24, 32'h10, 32'h40, 1'b0);
    wait_idle("t1");
    check("t1 nrd", 64'(rd_adr.size()), 3);
    check("t1 nbeat", 64'(bq.size()), 3);
    if (rd_adr.size() == 3 && bq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t1 rd_addr", 64'(rd_adr[i]), 64'h10 + 64'(i));
        check("t1 addr", 64'(bq[i].a), 64'h40 + 64'(i));
        check("t1 vec0", bq[i].v0, 64'hDA7A_0000_0000_0010 + 64'(i));
        check("t1 shift", 64'(bq[i].sh), 3);
        check("t1 be", 64'(bq[i].be), 64'hFF);
        check("t1 vec1", bq[i].v1, 0);
        check("t1 off", 64'(bq[i].off), 3);
        check("t1 start", 64'(bq[i].st), 64'(i == 0));
        check("t1 end", 64'(bq[i].en), 64'(i == 2));
        check("t1 lat", 64'(bq[i].cyc - rd_cyc[i]), 2);
      end
      check("t1 contig", 64'(bq[2].cyc - bq[0].cyc), 2);
      check("t1 ready ret", 64'(rdy_cyc - rd_cyc[2]), 3);
    end

    // T2: slide-down with insert, 20 bytes, offset 10
    clear_q();
    issue(1'b1, 1'b1, 64'hA5A5, 12'd10, 12'd20, 32'h100, 32'h200, 1'b0);
    wait_idle("t2");
    check("t2 nrd", 64'(rd_adr.size()), 3);
    check("t2 nbeat", 64'(bq.size()), 3);
    if (rd_adr.size() == 3 && bq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t2 rd_addr", 64'(rd_adr[i]), 64'h101 + 64'(i));
        check("t2 addr", 64'(bq[i].a), 64'h200 + 64'(i));
        check("t2 vec0", bq[i].v0, 64'hDA7A_0000_0000_0101 + 64'(i));
        check("t2 shift", 64'(bq[i].sh), 2);
        check("t2 opsel", 64'(bq[i].op), 1);
        check("t2 insert", 64'(bq[i].ins), 1);
        check("t2 off", 64'(bq[i].off), 10);
      end
      check("t2 vec1 b0", bq[0].v1, 0);
      check("t2 vec1 b1", bq[1].v1, 0);
      check("t2 vec1 b2", bq[2].v1, 64'hA5A5);
      check("t2 be b1", 64'(bq[1].be), 64'hFF);
      check("t2 be b2", 64'(bq[2].be), 64'h0F);
      check("t2 end", 64'(bq[2].en), 1);
    end

    // T3: slide-up single word with insert
    clear_q();
    issue(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 12'd0, 12'd4, 32'h20, 32'h30, 1'b0);
    wait_idle("t3");
    check("t3 nbeat", 64'(bq.size()), 1);
    if (bq.size() == 1 && rd_adr.size() == 1) begin
      check("t3 rd_addr", 64'(rd_adr[0]), 64'h20);
      check("t3 addr", 64'(bq[0].a), 64'h30);
      check("t3 start", 64'(bq[0].st), 1);
      check("t3 end", 64'(bq[0].en), 1);
      check("t3 vec1", bq[0].v1, 64'h1234_5678_9ABC_DEF0);
      check("t3 be", 64'(bq[0].be), 64'h0F);
    end

    // T4: zero-length command
    clear_q();
    issue(1'b0, 1'b0, 64'h0, 12'd5, 12'd0, 32'h40, 32'h50, 1'b0);
    check("t4 ready low", 64'(cmd_ready), 0);
    check("t4 busy", 64'(busy), 0);
    check("t4 rd_req", 64'(rd_req), 0);
    tick();
    check("t4 ready back", 64'(cmd_ready), 1);
    repeat (4) tick();
    check("t4 nrd", 64'(rd_adr.size()), 0);
    check("t4 nbeat", 64'(bq.size()), 0);

    // T5: reset in the middle of a 6-word command
    issue(1'b0, 1'b0, 64'h0, 12'd0, 12'd48, 32'h50, 32'h60, 1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    check("t5 rd_req", 64'(rd_req), 0);
    check("t5 rd_addr", 64'(rd_addr), 0);
    check("t5 out_valid", 64'(out_valid), 0);
    check("t5 out_vec0", out_vec0, 0);
    check("t5 out_addr", 64'(out_addr), 0);
    check("t5 out_start", 64'(out_start), 0);
    check("t5 busy", 64'(busy), 0);
    repeat (2) tick();
    rst = 1'b1;
    clear_q();
    repeat (8) tick();
    check("t5 nrd", 64'(rd_adr.size()), 0);
    check("t5 nbeat", 64'(bq.size()), 0);
    check("t5 ready", 64'(cmd_ready), 1);

    // T6: back-to-back with cmd_valid held high
    clear_q();
    issue(1'b0, 1'b0, 64'h0, 12'd8, 12'd16, 32'h70, 32'h80, 1'b1);
    cmd_opsel = 1'b1; cmd_offset = 12'd0; cmd_nbytes = 12'd8;
    cmd_src_base = 32'h90; cmd_dst_base = 32'hA0;
    begin
      int n = 0;
      while (!cmd_ready && n < 40) begin tick(); n++; end
      check("t6 second ready", 64'(n < 40), 1);
      tick();
      cmd_valid = 1'b0;
    end
    wait_idle("t6");
    check("t6 nrd", 64'(rd_adr.size()), 3);
    check("t6 nbeat", 64'(bq.size()), 3);
    if (rd_adr.size() == 3 && bq.size() == 3) begin
      check("t6 rd0", 64'(rd_adr[0]), 64'h70);
      check("t6 rd1", 64'(rd_adr[1]), 64'h71);
      check("t6 rd2", 64'(rd_adr[2]), 64'h90);
      check("t6 a0", 64'(bq[0].a), 64'h81);
      check("t6 a1", 64'(bq[1].a), 64'h82);
      check("t6 a2", 64'(bq[2].a), 64'hA0);
      check("t6 b start", 64'(bq[2].st), 1);
      check("t6 b end", 64'(bq[2].en), 1);
      check("t6 b be", 64'(bq[2].be), 64'hFF);
      check("t6 gap rd", 64'(rd_cyc[2] - bq[1].cyc), 2);
      check("t6 gap beat", 64'(bq[2].cyc - bq[1].cyc), 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
